l1_l2_req_arbiter: RTL and testbench

Sequencing arbiter placed between the L1 caches and the L2 request port. It accepts miss/refill requests from the Icache, read/write requests from the Dcache, and prefetch requests from the prefetcher, and issues exactly one transaction at a time to L2. It tracks the single outstanding transaction and routes the L2 addrOK/dataOK and refill data back to the owning requester. Icache flushes are absorbed by dropping the stale refill.

---
 rtl/l1_l2_req_arbiter_pkg.sv | 32 +++
 rtl/l1_l2_req_arbiter_if.sv | 65 ++++++
 rtl/l1_l2_req_arbiter_pick.sv | 58 +++++
 rtl/l1_l2_req_arbiter.sv | 129 ++++++++++++
 tb/tb_l1_l2_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_l2_req_arbiter_pkg.sv
// Shared types for the L1 -> L2 request arbiter: source codes, FSM states,
// the captured transaction record and the refill line width.
package l1_l2_arb_pkg;

    typedef enum logic [1:0] {
        SRC_I = 2'd0,
        SRC_D = 2'd1,
        SRC_P = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        src_e        src;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic        suc;
    } txn_t;

    // A refill line is 32 bits times 2^offset_width.
    function automatic int line_w(input int off_w);
        return 32 << off_w;
    endfunction

endpackage

// File: rtl/l1_l2_req_arbiter_if.sv
// Bundle of the Icache, Dcache, prefetcher and L2 signals around the arbiter.
// slave = the arbiter itself; master = the surrounding L1 caches and L2.
interface l1_l2_req_arbiter_if #(parameter int LINE_W = 128);
    logic              icache_arb_req;
    logic [31:0]       addr_icache_arb;
    logic              icache_arb_SUC;
    logic              icache_arb_flush;
    logic              arb_icache_addrOK;
    logic              arb_icache_dataOK;
    logic [LINE_W-1:0] dout_arb_icache;

    logic              dcache_arb_req;
    logic              dcache_arb_wr;
    logic [31:0]       addr_dcache_arb;
    logic [31:0]       din_dcache_arb;
    logic [3:0]        dcache_arb_wstrb;
    logic [1:0]        dcache_arb_size;
    logic              dcache_arb_SUC;
    logic              arb_dcache_addrOK;
    logic              arb_dcache_dataOK;
    logic [LINE_W-1:0] dout_arb_dcache;

    logic              req_pref_arb;
    logic [31:0]       addr_pref_arb;
    logic              addrOK_arb_pref;
    logic              complete_arb_pref;

    logic              arb_l2_req;
    logic              arb_l2_wr;
    logic [1:0]        arb_l2_src;
    logic [31:0]       addr_arb_l2;
    logic [31:0]       din_arb_l2;
    logic [3:0]        arb_l2_wstrb;
    logic [1:0]        arb_l2_size;
    logic              arb_l2_SUC;
    logic              l2_arb_addrOK;
    logic              l2_arb_dataOK;
    logic [LINE_W-1:0] dout_l2_arb;

    modport slave (
        input  icache_arb_req, addr_icache_arb, icache_arb_SUC, icache_arb_flush,
        output arb_icache_addrOK, arb_icache_dataOK, dout_arb_icache,
        input  dcache_arb_req, dcache_arb_wr, addr_dcache_arb, din_dcache_arb,
        input  dcache_arb_wstrb, dcache_arb_size, dcache_arb_SUC,
        output arb_dcache_addrOK, arb_dcache_dataOK, dout_arb_dcache,
        input  req_pref_arb, addr_pref_arb,
        output addrOK_arb_pref, complete_arb_pref,
        output arb_l2_req, arb_l2_wr, arb_l2_src, addr_arb_l2, din_arb_l2,
        output arb_l2_wstrb, arb_l2_size, arb_l2_SUC,
        input  l2_arb_addrOK, l2_arb_dataOK, dout_l2_arb
    );

    modport master (
        output icache_arb_req, addr_icache_arb, icache_arb_SUC, icache_arb_flush,
        input  arb_icache_addrOK, arb_icache_dataOK, dout_arb_icache,
        output dcache_arb_req, dcache_arb_wr, addr_dcache_arb, din_dcache_arb,
        output dcache_arb_wstrb, dcache_arb_size, dcache_arb_SUC,
        input  arb_dcache_addrOK, arb_dcache_dataOK, dout_arb_dcache,
        output req_pref_arb, addr_pref_arb,
        input  addrOK_arb_pref, complete_arb_pref,
        input  arb_l2_req, arb_l2_wr, arb_l2_src, addr_arb_l2, din_arb_l2,
        input  arb_l2_wstrb, arb_l2_size, arb_l2_SUC,
        output l2_arb_addrOK, l2_arb_dataOK, dout_l2_arb
    );
endinterface

// File: rtl/l1_l2_req_arbiter_pick.sv
// Priority pick D > I > P, with an anti-starvation counter that hands the
// grant to I after STARVE_LIMIT consecutive D grants taken while I waited.
module l1_l2_arb_pick
    import l1_l2_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic grant_en,
    input  logic i_req,
    input  logic d_req,
    input  logic p_req,
    output logic grant_vld,
    output src_e grant_src
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    // Winner selection among the live requests.
    always_comb begin
        grant_vld = i_req | d_req | p_req;
        if (d_req && !(i_req && (starve_cnt_q == LIMIT))) begin
            grant_src = SRC_D;
        end else if (i_req) begin
            grant_src = SRC_I;
        end else begin
            grant_src = SRC_P;
        end
    end

    // Starvation count: bump on a D grant that passed over a waiting I.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_en && grant_vld) begin
            if (grant_src == SRC_I) begin
                starve_cnt_d = 4'd0;
            end else if ((grant_src == SRC_D) && i_req && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: rtl/l1_l2_req_arbiter.sv
// Single-outstanding L1 -> L2 request arbiter. rstn is a synchronous,
// active-high reset; L2 handshakes are routed back to the owner combinationally.
module l1_l2_req_arbiter
    import l1_l2_arb_pkg::*;
#(
    parameter int L1_offset_width = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input logic                clk,
    input logic                rstn,
    l1_l2_req_arbiter_if.slave bus
);
    localparam int LINE_W = line_w(L1_offset_width);

    state_e            state_q;
    state_e            state_d;
    txn_t              txn_q;
    txn_t              txn_d;
    logic              drop_q;
    logic              drop_d;
    logic              in_idle_s;
    logic              grant_vld_s;
    src_e              grant_src_s;
    logic              addr_evt_s;
    logic              data_evt_s;
    logic              i_dok_s;
    logic              d_dok_s;
    logic [LINE_W-1:0] line_s;

    assign in_idle_s = (state_q == IDLE);
    assign line_s    = bus.dout_l2_arb;

    l1_l2_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk       (clk),
        .rstn      (rstn),
        .grant_en  (in_idle_s),
        .i_req     (bus.icache_arb_req),
        .d_req     (bus.dcache_arb_req),
        .p_req     (bus.req_pref_arb),
        .grant_vld (grant_vld_s),
        .grant_src (grant_src_s)
    );

    // State, captured transaction and flush-drop flag.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            txn_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_vld_s ? ISSUE : IDLE;
            ISSUE: begin
                if (bus.l2_arb_addrOK && bus.l2_arb_dataOK) begin
                    state_d = IDLE;
                end else if (bus.l2_arb_addrOK) begin
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT:    state_d = bus.l2_arb_dataOK ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Winner's fields are frozen at grant time; a flush of an owned I refill marks it stale.
    always_comb begin
        txn_d = txn_q;
        if (in_idle_s && grant_vld_s) begin
            case (grant_src_s)
                SRC_I:   txn_d = '{src: SRC_I, wr: 1'b0, addr: bus.addr_icache_arb, din: 32'd0,
                                   wstrb: 4'd0, size: 2'd2, suc: bus.icache_arb_SUC};
                SRC_D:   txn_d = '{src: SRC_D, wr: bus.dcache_arb_wr, addr: bus.addr_dcache_arb,
                                   din: bus.din_dcache_arb, wstrb: bus.dcache_arb_wstrb,
                                   size: bus.dcache_arb_size, suc: bus.dcache_arb_SUC};
                default: txn_d = '{src: SRC_P, wr: 1'b0, addr: bus.addr_pref_arb, din: 32'd0,
                                   wstrb: 4'd0, size: 2'd2, suc: 1'b0};
            endcase
        end else begin
            txn_d = txn_q;
        end
        if (in_idle_s) begin
            drop_d = 1'b0;
        end else if (bus.icache_arb_flush && (txn_q.src == SRC_I)) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
    end

    // L2 accept / data-return events; a dataOK alongside addrOK in ISSUE completes at once.
    always_comb begin
        addr_evt_s = (state_q == ISSUE) && bus.l2_arb_addrOK;
        data_evt_s = ((state_q == ISSUE) && bus.l2_arb_addrOK && bus.l2_arb_dataOK) ||
                     ((state_q == WAIT) && bus.l2_arb_dataOK);
        i_dok_s    = data_evt_s && (txn_q.src == SRC_I) && !drop_q && !bus.icache_arb_flush;
        d_dok_s    = data_evt_s && (txn_q.src == SRC_D);
    end

    // Output drive: L2 request side plus response routing to the owner.
    always_comb begin
        bus.arb_l2_req        = (state_q == ISSUE);
        bus.arb_l2_src        = txn_q.src;
        bus.arb_l2_wr         = txn_q.wr;
        bus.addr_arb_l2       = txn_q.addr;
        bus.din_arb_l2        = txn_q.din;
        bus.arb_l2_wstrb      = txn_q.wstrb;
        bus.arb_l2_size       = txn_q.size;
        bus.arb_l2_SUC        = txn_q.suc;
        bus.arb_icache_addrOK = addr_evt_s && (txn_q.src == SRC_I);
        bus.arb_dcache_addrOK = addr_evt_s && (txn_q.src == SRC_D);
        bus.addrOK_arb_pref   = addr_evt_s && (txn_q.src == SRC_P);
        bus.arb_icache_dataOK = i_dok_s;
        bus.arb_dcache_dataOK = d_dok_s;
        bus.complete_arb_pref = data_evt_s && (txn_q.src == SRC_P);
        bus.dout_arb_icache   = i_dok_s ? line_s : '0;
        bus.dout_arb_dcache   = d_dok_s ? line_s : '0;
    end
endmodule

// File: tb/tb_l1_l2_req_arbiter.sv
// Self-checking bench for l1_l2_req_arbiter: a vector table of single-source
// transactions plus hand-written starvation, prefetch and reset sequences.
module tb_l1_l2_req_arbiter;
    import l1_l2_arb_pkg::*;

    localparam int OFFW = 2;
    localparam int LW   = 32 << OFFW;

    typedef struct packed {
        logic [1:0]  src;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic        suc;
    } exp_t;

    // fmode: 0 none, 1 flush in first cycle after addrOK, 2 flush with addrOK+dataOK, 3 flush in IDLE
    typedef struct {
        logic [1:0]  src;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic        suc;
        int          adly;
        int          ddly;
        int          fmode;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic keep_i = 1'b0;
    logic keep_d = 1'b0;
    exp_t sb[$];
    vec_t vt[9];

    always #5 clk = ~clk;

    l1_l2_req_arbiter_if #(.LINE_W(LW)) bus();

    l1_l2_req_arbiter #(.L1_offset_width(OFFW), .STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] s, input logic wr, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] ws,
                                   input logic [1:0] sz, input logic suc);
        exp_t e;
        e.src  = s;
        e.addr = a;
        e.din  = d;
        if (s == 2'd1) begin
            e.wr = wr; e.wstrb = ws; e.size = sz; e.suc = suc;
        end else begin
            e.wr = 1'b0; e.wstrb = 4'd0; e.size = 2'd2; e.suc = (s == 2'd0) ? suc : 1'b0;
        end
        return e;
    endfunction

    function automatic logic [LW-1:0] mkline(input logic [31:0] a, input int k);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0BAD_F00D + 32'(k)};
    endfunction

    task automatic chk_hs(input string name, input logic [1:0] s, input logic aok, input logic dok,
                          input logic [LW-1:0] line, input logic sup);
        logic [5:0] exp_v;
        logic [5:0] act_v;
        logic       id;
        id    = dok && (s == 2'd0) && !sup;
        exp_v = {aok && (s == 2'd0), aok && (s == 2'd1), aok && (s == 2'd2),
                 id, dok && (s == 2'd1), dok && (s == 2'd2)};
        act_v = {bus.arb_icache_addrOK, bus.arb_dcache_addrOK, bus.addrOK_arb_pref,
                 bus.arb_icache_dataOK, bus.arb_dcache_dataOK, bus.complete_arb_pref};
        chk(name, LW'(act_v), LW'(exp_v));
        chk({name, "_idout"}, bus.dout_arb_icache, id ? line : '0);
        chk({name, "_ddout"}, bus.dout_arb_dcache, (dok && (s == 2'd1)) ? line : '0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req"},   LW'(bus.arb_l2_req), '0);
        chk({name, "_src"},   LW'(bus.arb_l2_src), '0);
        chk({name, "_wr"},    LW'(bus.arb_l2_wr), '0);
        chk({name, "_addr"},  LW'(bus.addr_arb_l2), '0);
        chk({name, "_din"},   LW'(bus.din_arb_l2), '0);
        chk({name, "_wstrb"}, LW'(bus.arb_l2_wstrb), '0);
        chk({name, "_size"},  LW'(bus.arb_l2_size), '0);
        chk({name, "_suc"},   LW'(bus.arb_l2_SUC), '0);
        chk_hs({name, "_resp"}, 2'd0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic release_owner(input logic [1:0] s);
        if (s == 2'd0 && !keep_i) bus.icache_arb_req = 1'b0;
        if (s == 2'd1 && !keep_d) bus.dcache_arb_req = 1'b0;
        if (s == 2'd2) bus.req_pref_arb = 1'b0;
    endtask

    // Acts as L2 for one transaction: addrOK adly cycles after req appears, dataOK ddly cycles later.
    task automatic serve(input int adly, input int ddly, input int fmode,
                         input logic [LW-1:0] line, input int exp_lat);
        exp_t e;
        int   n;
        logic sup;
        n = 0;
        while (bus.arb_l2_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            bus.icache_arb_flush = 1'b0;
            #1;
            n++;
        end
        chk("req_latency", LW'(n), LW'(exp_lat));
        if (bus.arb_l2_req !== 1'b1) return;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", LW'(1), LW'(0));
            return;
        end
        e = sb.pop_front();
        chk("l2_src",   LW'(bus.arb_l2_src), LW'(e.src));
        chk("l2_wr",    LW'(bus.arb_l2_wr), LW'(e.wr));
        chk("l2_addr",  LW'(bus.addr_arb_l2), LW'(e.addr));
        chk("l2_wstrb", LW'(bus.arb_l2_wstrb), LW'(e.wstrb));
        chk("l2_size",  LW'(bus.arb_l2_size), LW'(e.size));
        chk("l2_suc",   LW'(bus.arb_l2_SUC), LW'(e.suc));
        if (e.src == 2'd1) chk("l2_din", LW'(bus.din_arb_l2), LW'(e.din));
        for (int k = 0; k < adly; k++) begin
            chk("req_hold",  LW'(bus.arb_l2_req), LW'(1));
            chk("addr_hold", LW'(bus.addr_arb_l2), LW'(e.addr));
            chk_hs("pre_addrok_quiet", e.src, 1'b0, 1'b0, line, 1'b0);
            @(negedge clk);
            #1;
        end
        sup = (fmode == 1 || fmode == 2);
        bus.l2_arb_addrOK = 1'b1;
        if (ddly == 0) begin
            bus.l2_arb_dataOK    = 1'b1;
            bus.dout_l2_arb      = line;
            bus.icache_arb_flush = (fmode == 2);
        end
        #1;
        chk("req_at_addrok", LW'(bus.arb_l2_req), LW'(1));
        chk("addrok_din", LW'(bus.din_arb_l2), (e.src == 2'd1) ? LW'(e.din) : LW'(bus.din_arb_l2));
        chk_hs("addrok_resp", e.src, 1'b1, ddly == 0, line, sup);
        for (int k = 1; k <= ddly; k++) begin
            @(negedge clk);
            bus.l2_arb_addrOK = 1'b0;
            if (k == 1) release_owner(e.src);
            bus.icache_arb_flush = (fmode == 1 && k == 1);
            bus.l2_arb_dataOK    = (k == ddly);
            bus.dout_l2_arb      = (k == ddly) ? line : '0;
            #1;
            chk("req_low_in_wait", LW'(bus.arb_l2_req), LW'(0));
            chk_hs("wait_resp", e.src, 1'b0, k == ddly, line, sup);
        end
        @(negedge clk);
        bus.l2_arb_addrOK    = 1'b0;
        bus.l2_arb_dataOK    = 1'b0;
        bus.dout_l2_arb      = '0;
        bus.icache_arb_flush = 1'b0;
        if (ddly == 0) release_owner(e.src);
        #1;
        chk("idle_req_low", LW'(bus.arb_l2_req), LW'(0));
        chk_hs("idle_quiet", e.src, 1'b0, 1'b0, line, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'd0, 1'b0, 32'h1C00_0040, 32'h0,         4'h0, 2'd2, 1'b0, 1, 3, 0};
        vt[1] = '{2'd1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3, 2'd1, 1'b0, 3, 2, 0};
        vt[2] = '{2'd1, 1'b0, 32'h8000_0104, 32'h1234_5678, 4'hF, 2'd2, 1'b1, 0, 0, 0};
        vt[3] = '{2'd0, 1'b0, 32'hBFC0_0000, 32'h0,         4'h0, 2'd2, 1'b1, 0, 2, 1};
        vt[4] = '{2'd0, 1'b0, 32'h1C00_0080, 32'h0,         4'h0, 2'd2, 1'b0, 0, 1, 0};
        vt[5] = '{2'd2, 1'b1, 32'h2000_0000, 32'h0,         4'hF, 2'd0, 1'b1, 2, 1, 0};
        vt[6] = '{2'd0, 1'b0, 32'h1C00_00C0, 32'h0,         4'h0, 2'd2, 1'b0, 0, 0, 2};
        vt[7] = '{2'd0, 1'b0, 32'h1C00_0100, 32'h0,         4'h0, 2'd2, 1'b0, 1, 1, 3};
        vt[8] = '{2'd1, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'h8, 2'd0, 1'b0, 0, 2, 1};

        rstn = 1'b1;
        bus.icache_arb_req = 1'b0; bus.addr_icache_arb = '0; bus.icache_arb_SUC = 1'b0;
        bus.icache_arb_flush = 1'b0;
        bus.dcache_arb_req = 1'b0; bus.dcache_arb_wr = 1'b0; bus.addr_dcache_arb = '0;
        bus.din_dcache_arb = '0; bus.dcache_arb_wstrb = '0; bus.dcache_arb_size = '0;
        bus.dcache_arb_SUC = 1'b0;
        bus.req_pref_arb = 1'b0; bus.addr_pref_arb = '0;
        bus.l2_arb_addrOK = 1'b0; bus.l2_arb_dataOK = 1'b0; bus.dout_l2_arb = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_all_zero("post_reset");

        // Single-source vectors.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.icache_arb_req   = (vt[i].src == 2'd0);
            bus.dcache_arb_req   = (vt[i].src == 2'd1);
            bus.req_pref_arb     = (vt[i].src == 2'd2);
            bus.addr_icache_arb  = (vt[i].src == 2'd0) ? vt[i].addr : ~vt[i].addr;
            bus.addr_dcache_arb  = (vt[i].src == 2'd1) ? vt[i].addr : vt[i].addr ^ 32'hFFFF_0000;
            bus.addr_pref_arb    = (vt[i].src == 2'd2) ? vt[i].addr : vt[i].addr ^ 32'h0000_FFFF;
            bus.icache_arb_SUC   = vt[i].suc;
            bus.dcache_arb_wr    = vt[i].wr;
            bus.din_dcache_arb   = vt[i].din;
            bus.dcache_arb_wstrb = vt[i].wstrb;
            bus.dcache_arb_size  = vt[i].size;
            bus.dcache_arb_SUC   = vt[i].suc;
            bus.icache_arb_flush = (vt[i].fmode == 3);
            sb.push_back(model(vt[i].src, vt[i].wr, vt[i].addr, vt[i].din,
                               vt[i].wstrb, vt[i].size, vt[i].suc));
            #1;
            serve(vt[i].adly, vt[i].ddly, vt[i].fmode, mkline(vt[i].addr, i), 1);
        end

        // Starvation: I and D both requesting continuously.
        @(negedge clk);
        keep_i = 1'b1; keep_d = 1'b1;
        bus.icache_arb_req = 1'b1; bus.addr_icache_arb = 32'h1C00_1000; bus.icache_arb_SUC = 1'b0;
        bus.dcache_arb_req = 1'b1; bus.dcache_arb_wr = 1'b0; bus.addr_dcache_arb = 32'h0000_2000;
        bus.din_dcache_arb = 32'h0; bus.dcache_arb_wstrb = 4'h0; bus.dcache_arb_size = 2'd2;
        bus.dcache_arb_SUC = 1'b0;
        for (int g = 0; g < 11; g++) begin
            if (g == 4 || g == 9)
                sb.push_back(model(2'd0, 1'b0, 32'h1C00_1000, 32'h0, 4'h0, 2'd2, 1'b0));
            else
                sb.push_back(model(2'd1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 2'd2, 1'b0));
        end
        #1;
        for (int g = 0; g < 11; g++) begin
            if (g == 9)  keep_i = 1'b0;
            if (g == 10) keep_d = 1'b0;
            serve(0, 1, 0, mkline(32'h0000_3000, g), 1);
        end

        // Prefetch and D requesting together: D first, then P.
        @(negedge clk);
        bus.req_pref_arb = 1'b1; bus.addr_pref_arb = 32'h2000_0400;
        bus.dcache_arb_req = 1'b1; bus.dcache_arb_wr = 1'b1; bus.addr_dcache_arb = 32'h0000_0044;
        bus.din_dcache_arb = 32'hA5A5_0001; bus.dcache_arb_wstrb = 4'hC; bus.dcache_arb_size = 2'd1;
        sb.push_back(model(2'd1, 1'b1, 32'h0000_0044, 32'hA5A5_0001, 4'hC, 2'd1, 1'b0));
        sb.push_back(model(2'd2, 1'b0, 32'h2000_0400, 32'h0, 4'h0, 2'd2, 1'b0));
        #1;
        serve(0, 1, 0, mkline(32'h0000_0044, 50), 1);
        serve(1, 2, 0, mkline(32'h2000_0400, 51), 1);

        // Reset while an I refill is outstanding in WAIT; the late dataOK must be ignored.
        @(negedge clk);
        bus.icache_arb_req = 1'b1; bus.addr_icache_arb = 32'h1C00_2000; bus.icache_arb_SUC = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_seq_req", LW'(bus.arb_l2_req), LW'(1));
        bus.l2_arb_addrOK = 1'b1;
        #1;
        chk("rst_seq_addrok", LW'(bus.arb_icache_addrOK), LW'(1));
        @(negedge clk);
        bus.l2_arb_addrOK = 1'b0; bus.icache_arb_req = 1'b0;
        rstn = 1'b1;
        #1;
        chk("rst_seq_wait", LW'(bus.addr_arb_l2), LW'(32'h1C00_2000));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_all_zero("rst_in_wait");
        @(negedge clk);
        bus.l2_arb_dataOK = 1'b1; bus.dout_l2_arb = mkline(32'h1C00_2000, 60);
        #1;
        chk_all_zero("late_dataok");
        @(negedge clk);
        bus.l2_arb_dataOK = 1'b0; bus.dout_l2_arb = '0;
        #1;
        chk("sb_drained", LW'(sb.size()), LW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
